regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_writer.sv | 198 +++++++++++++++++++
 tb/tb_regfile_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
// ---------------------------------------------------------------------------
// regfile_writer
//
// Purpose:
//   A 32-entry register file with a single write port and a "clear" sweep.
//   Accepted writes go through a one-entry pending stage and commit on the
//   following edge.  A clear request starts a 32-cycle sweep that zeroes
//   one register per cycle, from index 0 to index 31.  New writes are not
//   accepted while the sweep runs.
//
// Configuration macro:
//   REGFILE_WRITER_ZERO_REG_EN - when defined, register 0 reads as a
//   constant zero.  Writes to address 0 still complete the handshake, but
//   their data is discarded.
//
// Parameters:
//   WIDTH     - bit width of each register and of wr_data
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous, active-high reset
//   wr_valid  - write request present
//   wr_ready  - write can be accepted this cycle (combinational)
//   wr_addr   - target register index 0..31
//   wr_data   - value to write
//   clear     - single-cycle request to start a zeroing sweep
//   busy      - sweep in progress
//   q0..q31   - current register contents
// ---------------------------------------------------------------------------
module regfile_writer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  output logic             busy,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic [WIDTH-1:0] q16,
  output logic [WIDTH-1:0] q17,
  output logic [WIDTH-1:0] q18,
  output logic [WIDTH-1:0] q19,
  output logic [WIDTH-1:0] q20,
  output logic [WIDTH-1:0] q21,
  output logic [WIDTH-1:0] q22,
  output logic [WIDTH-1:0] q23,
  output logic [WIDTH-1:0] q24,
  output logic [WIDTH-1:0] q25,
  output logic [WIDTH-1:0] q26,
  output logic [WIDTH-1:0] q27,
  output logic [WIDTH-1:0] q28,
  output logic [WIDTH-1:0] q29,
  output logic [WIDTH-1:0] q30,
  output logic [WIDTH-1:0] q31
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];

  logic             wr_accept;

  // A write is refused on the cycle clear is requested, so that the sweep
  // never races a newly accepted write.
  assign wr_ready  = (state_q == IDLE) && !clear;
  assign busy      = (state_q == CLEAR);
  assign wr_accept = wr_valid && wr_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pend_valid_d = wr_accept;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    regs_d       = regs_q;

    if (wr_accept) begin
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end

    // The pending write commits regardless of state.  This covers the edge
    // that enters CLEAR; the sweep zeroes that register later.
    if (pend_valid_q) begin
      regs_d[pend_addr_q] = pend_data_q;
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          idx_d   = 5'd0;
        end
      end
      CLEAR: begin
        // The sweep is applied after the commit so that it always wins.
        // A write cannot be pending here, though, because none is accepted
        // on the entry cycle.
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = IDLE;
        end
      end
    endcase

`ifdef REGFILE_WRITER_ZERO_REG_EN
    regs_d[0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 5'd0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 5'd0;
      pend_data_q  <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_WRITER_ZERO_REG_EN
  assign q0 = '0;
`else
  assign q0 = regs_q[0];
`endif
  assign q1  = regs_q[1];
  assign q2  = regs_q[2];
  assign q3  = regs_q[3];
  assign q4  = regs_q[4];
  assign q5  = regs_q[5];
  assign q6  = regs_q[6];
  assign q7  = regs_q[7];
  assign q8  = regs_q[8];
  assign q9  = regs_q[9];
  assign q10 = regs_q[10];
  assign q11 = regs_q[11];
  assign q12 = regs_q[12];
  assign q13 = regs_q[13];
  assign q14 = regs_q[14];
  assign q15 = regs_q[15];
  assign q16 = regs_q[16];
  assign q17 = regs_q[17];
  assign q18 = regs_q[18];
  assign q19 = regs_q[19];
  assign q20 = regs_q[20];
  assign q21 = regs_q[21];
  assign q22 = regs_q[22];
  assign q23 = regs_q[23];
  assign q24 = regs_q[24];
  assign q25 = regs_q[25];
  assign q26 = regs_q[26];
  assign q27 = regs_q[27];
  assign q28 = regs_q[28];
  assign q29 = regs_q[29];
  assign q30 = regs_q[30];
  assign q31 = regs_q[31];

endmodule

// File: tb/tb_regfile_writer.sv
// ---------------------------------------------------------------------------
// tb_regfile_writer
//
// Purpose:
//   Self-checking bench for regfile_writer.  A reference model tracks the
//   expected register contents, the pending write and the remaining sweep
//   length.  It is compared with every DUT output on each falling edge.
//   Directed sequences add hand-computed literal expectations.
//
// Configuration macro:
//   REGFILE_WRITER_ZERO_REG_EN - selects the expected behaviour of q0.
// ---------------------------------------------------------------------------
module tb_regfile_writer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_valid;
  logic             wr_ready;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clear;
  logic             busy;
  wire  [WIDTH-1:0] dut_q [32];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_regs [32];
  bit               m_pend;
  logic [4:0]       m_pend_addr;
  logic [WIDTH-1:0] m_pend_data;
  int               m_sweep_left;
  bit               m_live = 1'b0;

  always #5 clk = ~clk;

  regfile_writer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear(clear), .busy(busy),
    .q0(dut_q[0]),   .q1(dut_q[1]),   .q2(dut_q[2]),   .q3(dut_q[3]),
    .q4(dut_q[4]),   .q5(dut_q[5]),   .q6(dut_q[6]),   .q7(dut_q[7]),
    .q8(dut_q[8]),   .q9(dut_q[9]),   .q10(dut_q[10]), .q11(dut_q[11]),
    .q12(dut_q[12]), .q13(dut_q[13]), .q14(dut_q[14]), .q15(dut_q[15]),
    .q16(dut_q[16]), .q17(dut_q[17]), .q18(dut_q[18]), .q19(dut_q[19]),
    .q20(dut_q[20]), .q21(dut_q[21]), .q22(dut_q[22]), .q23(dut_q[23]),
    .q24(dut_q[24]), .q25(dut_q[25]), .q26(dut_q[26]), .q27(dut_q[27]),
    .q28(dut_q[28]), .q29(dut_q[29]), .q30(dut_q[30]), .q31(dut_q[31])
  );

  // One comparison, which counts and reports any failure
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge that
  // samples them.
  task automatic applyStimulus(input logic v, input logic [4:0] a,
                               input logic [WIDTH-1:0] d, input logic c,
                               input logic r);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clear    = c;
    reset    = r;
    @(posedge clk);
    #1;
  endtask

  // Model: a write becomes visible one edge after it is accepted.  A sweep
  // lasts 32 edges and zeroes register (32 - remaining) on each edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend       = 1'b0;
      m_sweep_left = 0;
      m_live       = 1'b1;
    end else if (m_live) begin
      bit acc;
      acc = wr_valid && (m_sweep_left == 0) && !clear;
      if (m_pend) m_regs[m_pend_addr] = m_pend_data;
`ifdef REGFILE_WRITER_ZERO_REG_EN
      m_regs[0] = '0;
`endif
      if (m_sweep_left > 0) begin
        m_regs[32 - m_sweep_left] = '0;
        m_sweep_left--;
      end else if (clear) begin
        m_sweep_left = 32;
      end
      m_pend      = acc;
      m_pend_addr = wr_addr;
      m_pend_data = wr_data;
    end
  end

  // Compare all outputs against the model on every falling edge
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 32; i++) begin
        checkOutput($sformatf("model_q%0d", i), dut_q[i], m_regs[i]);
      end
      checkOutput("model_busy", {31'd0, busy}, {31'd0, m_sweep_left > 0});
      checkOutput("model_wr_ready", {31'd0, wr_ready},
                  {31'd0, (m_sweep_left == 0) && !clear});
    end
  end

  initial begin
    int busy_cycles;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear = 1'b0; reset = 1'b1;

    // Reset
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ready", {31'd0, wr_ready}, 32'd1);
    checkOutput("reset_q5", dut_q[5], 32'd0);

    // A single write is visible one cycle after it is accepted
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0);
    checkOutput("single_q5_pending", dut_q[5], 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("single_q5", dut_q[5], 32'hDEADBEEF);
    checkOutput("single_q4", dut_q[4], 32'd0);

    // Back-to-back writes with no bubbles; the last write to an address wins
    wr_valid = 1; wr_addr = 7; wr_data = 32'h1; #1;
    checkOutput("b2b_ready0", {31'd0, wr_ready}, 32'd1);
    applyStimulus(1, 7, 32'h1, 0, 0);
    checkOutput("b2b_ready1", {31'd0, wr_ready}, 32'd1);
    applyStimulus(1, 7, 32'h2, 0, 0);
    checkOutput("b2b_q7_first", dut_q[7], 32'h1);
    applyStimulus(1, 8, 32'h3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("b2b_q7", dut_q[7], 32'h2);
    checkOutput("b2b_q8", dut_q[8], 32'h3);

    // Fill every register, then sweep.  wr_valid is held high throughout,
    // and clear toggles while the sweep runs.
    for (int i = 0; i < 32; i++) applyStimulus(1, i[4:0], 32'h100 + i, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fill_q31", dut_q[31], 32'h11F);
    checkOutput("fill_q0", dut_q[0],
`ifdef REGFILE_WRITER_ZERO_REG_EN
                32'h0);
`else
                32'h100);
`endif
    applyStimulus(0, 0, 0, 1, 0);
    busy_cycles = 0;
    for (int k = 0; k < 32; k++) begin
      if (busy) busy_cycles++;
      checkOutput($sformatf("sweep_before_q%0d", k), dut_q[k],
                  (k == 0) ? m_regs[0] : 32'h100 + k);
      applyStimulus(1, 9, 32'h55, k[0], 0);
      checkOutput($sformatf("sweep_after_q%0d", k), dut_q[k], 32'd0);
    end
    checkOutput("sweep_busy_cycles", busy_cycles, 32'd32);
    checkOutput("sweep_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("sweep_q9_no_accept", dut_q[9], 32'd0);
    // The stalled write is accepted on the first IDLE cycle without clear
    applyStimulus(1, 9, 32'h55, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall_q9", dut_q[9], 32'h55);

    // The pending write commits on the sweep-entry edge, then is zeroed
    applyStimulus(1, 3, 32'hAA, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pend_q3", dut_q[3], 32'hAA);
    checkOutput("pend_busy", {31'd0, busy}, 32'd1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pend_q3_held", dut_q[3], 32'hAA);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pend_q3_zeroed", dut_q[3], 32'd0);
    repeat (28) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pend_sweep_done", {31'd0, busy}, 32'd0);

    // Reset aborts a sweep that is in progress
    applyStimulus(1, 31, 32'h1234, 0, 0);
    applyStimulus(1, 20, 32'h5678, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_q31_pre", dut_q[31], 32'h1234);
    applyStimulus(0, 0, 0, 1, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_busy_pre", {31'd0, busy}, 32'd1);
    applyStimulus(1, 4, 32'h9, 1, 1);
    wr_valid = 0; clear = 0; reset = 0; #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, wr_ready}, 32'd1);
    checkOutput("abort_q31", dut_q[31], 32'd0);
    checkOutput("abort_q20", dut_q[20], 32'd0);

    // Writes to address 0
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
`ifdef REGFILE_WRITER_ZERO_REG_EN
    checkOutput("zero_reg_q0", dut_q[0], 32'd0);
`else
    checkOutput("zero_reg_q0", dut_q[0], 32'hFFFFFFFF);
`endif

    applyStimulus(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
